// File: rtl/svc_axi_sram_if_pkg.sv
// Shared constants for the AXI-to-SRAM bridge: burst encodings and response codes.
package svc_axi_sram_if_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

endpackage

// File: rtl/svc_axi_burst_iter.sv
// Burst address walker: loads AXI burst parameters, steps the byte address per beat,
// and flags the final beat (beat count == len).
module svc_axi_burst_iter
    import svc_axi_sram_if_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;

    always_comb begin
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        if (load_i) begin
            addr_d  = addr_i;
            len_d   = len_i;
            cnt_d   = 8'd0;
            size_d  = size_i;
            burst_d = burst_i;
        end else if (adv_i) begin
            cnt_d = cnt_q + 8'd1;
            // WRAP bursts deliberately walk linearly like INCR
            if (burst_q != BURST_FIXED) begin
                addr_d = addr_q + ({{(ADDR_W-1){1'b0}}, 1'b1} << size_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_INCR;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == len_q);

endmodule

// File: rtl/svc_axi_sram_if.sv
// AXI4 slave to single SRAM command stream; write beats pass straight through, reads are
// issued one per cycle from registered burst state, and read responses map onto R combinationally.
module svc_axi_sram_if
    import svc_axi_sram_if_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    localparam int LSB     = $clog2(AXI_DATA_WIDTH) - 3,
    localparam int SRAM_AW = AXI_ADDR_WIDTH - LSB,
    localparam int META_W  = AXI_ID_WIDTH + 1,
    localparam int STRB_W  = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0]         s_axi_wstrb,
    input  logic                      s_axi_wlast,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      sram_cmd_valid,
    input  logic                      sram_cmd_ready,
    output logic                      sram_cmd_wr_en,
    output logic [SRAM_AW-1:0]        sram_cmd_addr,
    output logic [META_W-1:0]         sram_cmd_meta,
    output logic [AXI_DATA_WIDTH-1:0] sram_cmd_wr_data,
    output logic [STRB_W-1:0]         sram_cmd_wr_strb,
    input  logic                      sram_rd_resp_valid,
    output logic                      sram_rd_resp_ready,
    input  logic [AXI_DATA_WIDTH-1:0] sram_rd_resp_data,
    input  logic [META_W-1:0]         sram_rd_resp_meta
);

    logic w_active_q, w_active_d;
    logic bvalid_q, bvalid_d;
    logic r_active_q, r_active_d;
    logic last_rd_q, last_rd_d;
    logic [AXI_ID_WIDTH-1:0] awid_q, awid_d;
    logic [AXI_ID_WIDTH-1:0] arid_q, arid_d;

    logic aw_hs, ar_hs, w_req, r_req, wr_gnt, rd_gnt, w_adv, r_adv;
    logic w_last, r_last;
    logic [AXI_ADDR_WIDTH-1:0] w_addr, r_addr;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign w_req = w_active_q && s_axi_wvalid;
    assign r_req = r_active_q;

    // Contention goes to whichever side did not win the previous command handshake
    assign wr_gnt = w_req && (!r_req || last_rd_q);
    assign rd_gnt = r_req && (!w_req || !last_rd_q);
    assign w_adv  = wr_gnt && sram_cmd_ready;
    assign r_adv  = rd_gnt && sram_cmd_ready;

    svc_axi_burst_iter #(.ADDR_W(AXI_ADDR_WIDTH)) u_w_iter (
        .clk(clk), .rst_n(rst_n), .load_i(aw_hs), .addr_i(s_axi_awaddr), .len_i(s_axi_awlen),
        .size_i(s_axi_awsize), .burst_i(s_axi_awburst), .adv_i(w_adv), .addr_o(w_addr), .last_o(w_last)
    );

    svc_axi_burst_iter #(.ADDR_W(AXI_ADDR_WIDTH)) u_r_iter (
        .clk(clk), .rst_n(rst_n), .load_i(ar_hs), .addr_i(s_axi_araddr), .len_i(s_axi_arlen),
        .size_i(s_axi_arsize), .burst_i(s_axi_arburst), .adv_i(r_adv), .addr_o(r_addr), .last_o(r_last)
    );

    always_comb begin
        w_active_d = w_active_q;
        bvalid_d   = bvalid_q;
        r_active_d = r_active_q;
        last_rd_d  = last_rd_q;
        awid_d     = awid_q;
        arid_d     = arid_q;
        if (aw_hs) begin
            w_active_d = 1'b1;
            awid_d     = s_axi_awid;
        end else if (w_adv && w_last) begin
            w_active_d = 1'b0;
        end
        if (w_adv && w_last) begin
            bvalid_d = 1'b1;
        end else if (s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (ar_hs) begin
            r_active_d = 1'b1;
            arid_d     = s_axi_arid;
        end else if (r_adv && r_last) begin
            r_active_d = 1'b0;
        end
        if (w_adv) begin
            last_rd_d = 1'b0;
        end else if (r_adv) begin
            last_rd_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_active_q <= 1'b0;
            bvalid_q   <= 1'b0;
            r_active_q <= 1'b0;
            last_rd_q  <= 1'b0;
            awid_q     <= '0;
            arid_q     <= '0;
        end else begin
            w_active_q <= w_active_d;
            bvalid_q   <= bvalid_d;
            r_active_q <= r_active_d;
            last_rd_q  <= last_rd_d;
            awid_q     <= awid_d;
            arid_q     <= arid_d;
        end
    end

    assign s_axi_awready = !w_active_q && !bvalid_q;
    assign s_axi_wready  = w_adv;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = awid_q;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = !r_active_q;

    assign sram_cmd_valid   = wr_gnt || rd_gnt;
    assign sram_cmd_wr_en   = wr_gnt;
    assign sram_cmd_addr    = wr_gnt ? w_addr[AXI_ADDR_WIDTH-1:LSB] : r_addr[AXI_ADDR_WIDTH-1:LSB];
    assign sram_cmd_meta    = wr_gnt ? {awid_q, w_last} : {arid_q, r_last};
    assign sram_cmd_wr_data = s_axi_wdata;
    assign sram_cmd_wr_strb = s_axi_wstrb;

    assign s_axi_rvalid       = sram_rd_resp_valid;
    assign s_axi_rdata        = sram_rd_resp_data;
    assign s_axi_rid          = sram_rd_resp_meta[META_W-1:1];
    assign s_axi_rlast        = sram_rd_resp_meta[0];
    assign s_axi_rresp        = RESP_OKAY;
    assign sram_rd_resp_ready = s_axi_rready;

    // Burst length alone terminates writes; byte-lane address bits never reach the SRAM
    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_wlast, w_addr[LSB-1:0], r_addr[LSB-1:0]};

endmodule

// File: tb/tb_svc_axi_sram_if.sv
// Bench for svc_axi_sram_if: behavioural 1-cycle SRAM, vector table for the R mapping,
// directed corner sequences, then random bursts checked against a word-level reference memory.
module tb_svc_axi_sram_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axi_awvalid, s_axi_awready;
    logic [3:0]  s_axi_awid;
    logic [19:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_wvalid, s_axi_wready;
    logic [15:0] s_axi_wdata;
    logic [1:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [3:0]  s_axi_arid;
    logic [19:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_rvalid, s_axi_rready;
    logic [3:0]  s_axi_rid;
    logic [15:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        sram_cmd_valid, sram_cmd_ready, sram_cmd_wr_en;
    logic [18:0] sram_cmd_addr;
    logic [4:0]  sram_cmd_meta;
    logic [15:0] sram_cmd_wr_data;
    logic [1:0]  sram_cmd_wr_strb;
    logic        sram_rd_resp_valid, sram_rd_resp_ready;
    logic [15:0] sram_rd_resp_data;
    logic [4:0]  sram_rd_resp_meta;

    int n_cmp = 0;
    int n_bad = 0;
    logic model_en, rnd_mode;
    logic t_vld;
    logic [15:0] t_dat;
    logic [4:0]  t_meta;

    svc_axi_sram_if dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .sram_cmd_valid(sram_cmd_valid), .sram_cmd_ready(sram_cmd_ready),
        .sram_cmd_wr_en(sram_cmd_wr_en), .sram_cmd_addr(sram_cmd_addr),
        .sram_cmd_meta(sram_cmd_meta), .sram_cmd_wr_data(sram_cmd_wr_data),
        .sram_cmd_wr_strb(sram_cmd_wr_strb),
        .sram_rd_resp_valid(sram_rd_resp_valid), .sram_rd_resp_ready(sram_rd_resp_ready),
        .sram_rd_resp_data(sram_rd_resp_data), .sram_rd_resp_meta(sram_rd_resp_meta)
    );

    always #5 clk = ~clk;

    // ---------------- SRAM model: 1-cycle latency, uninitialised word reads its own address
    typedef struct packed { logic [15:0] dat; logic [4:0] meta; } resp_t;
    resp_t       rq[$];
    logic [15:0] mem [logic [18:0]];
    logic [15:0] mw;
    logic        m_vld = 1'b0;
    logic [15:0] m_dat = '0;
    logic [4:0]  m_meta = '0;

    always @(posedge clk) begin
        if (m_vld && sram_rd_resp_ready && rq.size() > 0) void'(rq.pop_front());
        if (sram_cmd_valid && sram_cmd_ready) begin
            mw = mem.exists(sram_cmd_addr) ? mem[sram_cmd_addr] : 16'(sram_cmd_addr);
            if (sram_cmd_wr_en) begin
                for (int j = 0; j < 2; j++)
                    if (sram_cmd_wr_strb[j]) mw[8*j +: 8] = sram_cmd_wr_data[8*j +: 8];
                mem[sram_cmd_addr] = mw;
            end else begin
                rq.push_back('{dat: mw, meta: sram_cmd_meta});
            end
        end
        m_vld  <= (rq.size() > 0);
        m_dat  <= (rq.size() > 0) ? rq[0].dat : 16'h0;
        m_meta <= (rq.size() > 0) ? rq[0].meta : 5'h0;
    end

    assign sram_rd_resp_valid = model_en ? m_vld  : t_vld;
    assign sram_rd_resp_data  = model_en ? m_dat  : t_dat;
    assign sram_rd_resp_meta  = model_en ? m_meta : t_meta;

    // ---------------- monitors
    typedef struct packed { logic wr; logic [18:0] addr; logic [4:0] meta; logic [15:0] dat; logic [1:0] strb; } cmd_t;
    typedef struct packed { logic [15:0] dat; logic [3:0] id; logic last; } rbeat_t;
    cmd_t       cmd_log[$];
    rbeat_t     r_log[$];
    logic [3:0] b_log[$];
    logic        p_stall = 1'b0;
    logic        p_wr = 1'b0;
    logic [18:0] p_addr = '0;
    logic [4:0]  p_meta = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (p_stall) begin
                chk("stall_valid", {31'd0, sram_cmd_valid}, 32'd1);
                chk("stall_cmd", {7'd0, sram_cmd_wr_en, sram_cmd_addr, sram_cmd_meta},
                    {7'd0, p_wr, p_addr, p_meta});
            end
            if (sram_cmd_valid && sram_cmd_ready)
                cmd_log.push_back('{wr: sram_cmd_wr_en, addr: sram_cmd_addr, meta: sram_cmd_meta,
                                    dat: sram_cmd_wr_data, strb: sram_cmd_wr_strb});
            if (s_axi_rvalid && s_axi_rready)
                r_log.push_back('{dat: s_axi_rdata, id: s_axi_rid, last: s_axi_rlast});
            if (s_axi_bvalid && s_axi_bready) b_log.push_back(s_axi_bid);
        end
        p_stall <= sram_cmd_valid && !sram_cmd_ready;
        p_wr    <= sram_cmd_wr_en;
        p_addr  <= sram_cmd_addr;
        p_meta  <= sram_cmd_meta;
    end

    // ---------------- reference model: word memory computed from byte-address arithmetic
    logic [15:0] ref_mem [logic [18:0]];

    function automatic logic [18:0] beat_word(input logic [19:0] a, input int k,
                                              input logic [2:0] size, input logic [1:0] bt);
        logic [19:0] b;
        b = (bt == 2'd0) ? a : a + 20'(k << size);
        return b[19:1];
    endfunction

    function automatic logic [15:0] ref_rd(input logic [18:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : 16'(w);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rnd_mode) sram_cmd_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [19:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] bt);
        s_axi_awvalid = 1'b1; s_axi_awid = id; s_axi_awaddr = a;
        s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = bt;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [19:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] bt);
        s_axi_arvalid = 1'b1; s_axi_arid = id; s_axi_araddr = a;
        s_axi_arlen = len; s_axi_arsize = size; s_axi_arburst = bt;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [19:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] bt);
        cmd_t ex[$];
        int   to;
        logic [18:0] w;
        logic [15:0] v;
        cmd_log.delete(); b_log.delete();
        set_aw(id, a, len, size, bt);
        #1; to = 0;
        while (!s_axi_awready && to < 200) begin cyc(); #1; to++; end
        chk("aw_timeout", to, (to < 200) ? to : 199);
        cyc(); s_axi_awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            while ($urandom_range(0, 2) == 0) cyc();
            s_axi_wdata = 16'($urandom); s_axi_wstrb = 2'($urandom_range(1, 3));
            s_axi_wlast = (k == int'(len));
            w = beat_word(a, k, size, bt);
            v = ref_rd(w);
            for (int j = 0; j < 2; j++) if (s_axi_wstrb[j]) v[8*j +: 8] = s_axi_wdata[8*j +: 8];
            ref_mem[w] = v;
            ex.push_back('{wr: 1'b1, addr: w, meta: {id, k == int'(len)}, dat: s_axi_wdata, strb: s_axi_wstrb});
            s_axi_wvalid = 1'b1;
            #1; to = 0;
            while (!s_axi_wready && to < 200) begin cyc(); #1; to++; end
            chk("w_timeout", to, (to < 200) ? to : 199);
            cyc(); s_axi_wvalid = 1'b0;
        end
        to = 0;
        while (b_log.size() == 0 && to < 200) begin s_axi_bready = $urandom_range(0, 1); cyc(); to++; end
        s_axi_bready = 1'b1;
        chk("rnd_b_count", b_log.size(), 1);
        if (b_log.size() > 0) chk("rnd_bid", b_log[0], id);
        chk("rnd_wcmd_count", cmd_log.size(), ex.size());
        for (int k = 0; k < ex.size() && k < cmd_log.size(); k++)
            chk("rnd_wcmd", cmd_log[k], ex[k]);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [19:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt);
        int to;
        logic [18:0] w;
        cmd_log.delete(); r_log.delete();
        set_ar(id, a, len, size, bt);
        #1; to = 0;
        while (!s_axi_arready && to < 200) begin cyc(); #1; to++; end
        chk("ar_timeout", to, (to < 200) ? to : 199);
        cyc(); s_axi_arvalid = 1'b0;
        to = 0;
        while (r_log.size() < int'(len) + 1 && to < 600) begin
            s_axi_rready = ($urandom_range(0, 2) != 0); cyc(); to++;
        end
        s_axi_rready = 1'b1;
        chk("rnd_r_count", r_log.size(), int'(len) + 1);
        chk("rnd_rcmd_count", cmd_log.size(), int'(len) + 1);
        for (int k = 0; k <= int'(len); k++) begin
            w = beat_word(a, k, size, bt);
            if (k < r_log.size())
                chk("rnd_rbeat", r_log[k], {ref_rd(w), id, k == int'(len)});
            if (k < cmd_log.size())
                chk("rnd_rcmd", {cmd_log[k].wr, cmd_log[k].addr, cmd_log[k].meta},
                    {1'b0, w, id, k == int'(len)});
        end
    endtask

    // ---------------- R-channel mapping vectors
    typedef struct {
        logic vld; logic [15:0] dat; logic [4:0] meta; logic rdy;
        logic e_vld; logic [15:0] e_dat; logic [3:0] e_id; logic e_last; logic e_rdy;
    } tv_t;
    tv_t tv[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; model_en = 1'b0; rnd_mode = 1'b0;
        t_vld = 1'b0; t_dat = '0; t_meta = '0;
        s_axi_awvalid = 0; s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
        s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_bready = 1;
        s_axi_arvalid = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
        s_axi_rready = 1; sram_cmd_ready = 1;
        #1;
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_cmd_valid", sram_cmd_valid, 0);
        repeat (3) cyc();
        rst_n = 1'b1; #1;
        chk("rst_awready", s_axi_awready, 1);
        chk("rst_arready", s_axi_arready, 1);

        tv[0] = '{1'b1, 16'h1234, 5'b1011_1, 1'b1, 1'b1, 16'h1234, 4'hB, 1'b1, 1'b1};
        tv[1] = '{1'b1, 16'hBEEF, 5'b0011_0, 1'b0, 1'b1, 16'hBEEF, 4'h3, 1'b0, 1'b0};
        tv[2] = '{1'b0, 16'h0000, 5'b1111_1, 1'b1, 1'b0, 16'h0000, 4'hF, 1'b1, 1'b1};
        tv[3] = '{1'b1, 16'hFFFF, 5'b0000_1, 1'b0, 1'b1, 16'hFFFF, 4'h0, 1'b1, 1'b0};
        tv[4] = '{1'b1, 16'h5A5A, 5'b1000_0, 1'b1, 1'b1, 16'h5A5A, 4'h8, 1'b0, 1'b1};
        tv[5] = '{1'b0, 16'hA5A5, 5'b0110_0, 1'b0, 1'b0, 16'hA5A5, 4'h6, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            t_vld = tv[i].vld; t_dat = tv[i].dat; t_meta = tv[i].meta; s_axi_rready = tv[i].rdy;
            #1;
            chk("tv_r", {s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rlast, s_axi_rresp, sram_rd_resp_ready},
                {tv[i].e_vld, tv[i].e_dat, tv[i].e_id, tv[i].e_last, 2'b00, tv[i].e_rdy});
        end
        t_vld = 1'b0; s_axi_rready = 1'b1; model_en = 1'b1;
        cyc();

        // read burst len 3 INCR size 1 at 0xA000, id B
        set_ar(4'hB, 20'hA000, 8'd3, 3'd1, 2'd1);
        cyc(); s_axi_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rb_cmd", {sram_cmd_valid, sram_cmd_wr_en, sram_cmd_addr, sram_cmd_meta},
                {1'b1, 1'b0, 19'h5000 + 19'(i), 4'hB, i == 3});
            if (i > 0) chk("rb_r", {s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rlast},
                           {1'b1, 16'h5000 + 16'(i - 1), 4'hB, 1'b0});
            cyc();
        end
        #1;
        chk("rb_cmd_idle", sram_cmd_valid, 0);
        chk("rb_rlast", {s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rlast}, {1'b1, 16'h5003, 4'hB, 1'b1});
        cyc(); #1;
        chk("rb_rvalid_off", s_axi_rvalid, 0);

        // single read with rready low: response held
        s_axi_rready = 1'b0;
        set_ar(4'h2, 20'hA010, 8'd0, 3'd1, 2'd1);
        cyc(); s_axi_arvalid = 1'b0; #1;
        chk("sr_cmd", {sram_cmd_valid, sram_cmd_addr, sram_cmd_meta}, {1'b1, 19'h5008, 4'h2, 1'b1});
        cyc(); #1;
        chk("sr_r0", {s_axi_rvalid, s_axi_rdata, sram_rd_resp_ready}, {1'b1, 16'h5008, 1'b0});
        cyc(); #1;
        chk("sr_r1", {s_axi_rvalid, s_axi_rdata, s_axi_rlast}, {1'b1, 16'h5008, 1'b1});
        s_axi_rready = 1'b1; #1;
        chk("sr_rdy_comb", sram_rd_resp_ready, 1);
        cyc(); #1;
        chk("sr_rvalid_off", s_axi_rvalid, 0);

        // W alone is held off, then AW arrives a cycle later
        s_axi_wvalid = 1'b1; s_axi_wdata = 16'hD000; s_axi_wstrb = 2'b11; s_axi_wlast = 1'b1; #1;
        chk("wo_hold", {sram_cmd_valid, s_axi_wready, s_axi_bvalid}, 0);
        chk("wo_pass", {sram_cmd_wr_data, sram_cmd_wr_strb}, {16'hD000, 2'b11});
        cyc();
        set_aw(4'hB, 20'hA000, 8'd0, 3'd1, 2'd1); #1;
        chk("wf_hold", sram_cmd_valid, 0);
        cyc(); s_axi_awvalid = 1'b0; #1;
        chk("wf_cmd", {sram_cmd_valid, sram_cmd_wr_en, sram_cmd_addr, sram_cmd_wr_data, s_axi_wready},
            {1'b1, 1'b1, 19'h5000, 16'hD000, 1'b1});
        cyc(); s_axi_wvalid = 1'b0; #1;
        chk("wf_b", {s_axi_bvalid, s_axi_bid, s_axi_bresp, s_axi_awready}, {1'b1, 4'hB, 2'b00, 1'b0});
        cyc(); #1;
        chk("wf_b_off", {s_axi_bvalid, s_axi_awready}, {1'b0, 1'b1});

        // AW alone, then W
        set_aw(4'hB, 20'hA000, 8'd0, 3'd1, 2'd1);
        cyc(); s_axi_awvalid = 1'b0; #1;
        chk("ao_0", {sram_cmd_valid, s_axi_bvalid}, 0);
        cyc(); #1;
        chk("ao_1", {sram_cmd_valid, s_axi_bvalid}, 0);
        s_axi_wvalid = 1'b1; s_axi_wdata = 16'hD000; #1;
        chk("aw_w_cmd", {sram_cmd_valid, sram_cmd_addr, sram_cmd_wr_data}, {1'b1, 19'h5000, 16'hD000});
        cyc(); s_axi_wvalid = 1'b0; #1;
        chk("aw_w_b", {s_axi_bvalid, s_axi_bid}, {1'b1, 4'hB});
        cyc(); #1;
        chk("aw_w_b_off", s_axi_bvalid, 0);

        // write burst len 3 INCR size 1
        set_aw(4'hB, 20'hA000, 8'd3, 3'd1, 2'd1);
        cyc(); s_axi_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = 16'hD000 + 16'(i); s_axi_wlast = (i == 3); #1;
            chk("wb_cmd", {sram_cmd_valid, sram_cmd_addr, sram_cmd_wr_data, s_axi_bvalid},
                {1'b1, 19'h5000 + 19'(i), 16'hD000 + 16'(i), 1'b0});
            cyc();
        end
        s_axi_wvalid = 1'b0; #1;
        chk("wb_b", {s_axi_bvalid, s_axi_bid}, {1'b1, 4'hB});
        cyc(); #1;
        chk("wb_b_off", s_axi_bvalid, 0);

        // contention: last grant was a write, so read goes first, then alternate; includes a stall
        cmd_log.delete(); r_log.delete(); b_log.delete();
        set_aw(4'h3, 20'h8000, 8'd1, 3'd1, 2'd1);
        set_ar(4'h5, 20'h8100, 8'd1, 3'd1, 2'd1);
        cyc(); s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 16'h1111; s_axi_wlast = 1'b0; sram_cmd_ready = 1'b0; #1;
        chk("arb_stall", {sram_cmd_valid, sram_cmd_wr_en, sram_cmd_addr, s_axi_wready}, {1'b1, 1'b0, 19'h4080, 1'b0});
        cyc(); #1;
        chk("arb_stall_hold", {sram_cmd_wr_en, sram_cmd_addr}, {1'b0, 19'h4080});
        sram_cmd_ready = 1'b1;
        cyc(); #1;
        chk("arb_w0", {sram_cmd_wr_en, sram_cmd_addr, sram_cmd_wr_data}, {1'b1, 19'h4000, 16'h1111});
        cyc(); s_axi_wdata = 16'h2222; s_axi_wlast = 1'b1; #1;
        chk("arb_r1", {sram_cmd_wr_en, sram_cmd_addr, sram_cmd_meta}, {1'b0, 19'h4081, 4'h5, 1'b1});
        cyc(); #1;
        chk("arb_w1", {sram_cmd_wr_en, sram_cmd_addr, sram_cmd_wr_data}, {1'b1, 19'h4001, 16'h2222});
        cyc(); s_axi_wvalid = 1'b0;
        repeat (3) cyc();
        chk("arb_b", b_log.size() > 0 ? {28'd0, b_log[0]} : 32'hDEAD, 32'h3);
        chk("arb_rdata", r_log.size() == 2 ? {r_log[0].dat, r_log[1].dat} : 32'hDEAD, {16'h4080, 16'h4081});

        // random bursts against the reference memory
        rnd_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  sz;
            logic [19:0] a;
            sz = 3'($urandom_range(0, 1));
            a  = 20'($urandom_range(0, 'h3F0));
            if (sz == 3'd1) a[0] = 1'b0;
            if ($urandom_range(0, 1) == 0)
                do_write(4'($urandom), a, 8'($urandom_range(0, 7)), sz, 2'($urandom_range(0, 2)));
            else
                do_read(4'($urandom), a, 8'($urandom_range(0, 7)), sz, 2'($urandom_range(0, 2)));
        end
        rnd_mode = 1'b0; sram_cmd_ready = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
